// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: majority-samples the line with an external oversampling
// edge counter, walks start/data/parity/stop and delivers a byte with parity/stop error pulses.
module uart_rx_fsm #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic [5:0]        scale,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic [4:0]        edge_count,
    input  logic              edge_done,
    output logic              edge_cnt_en,
    output logic [DATA_W-1:0] p_data,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [3:0]        bit_cnt;
    logic              par_fail;
    logic              samp_bit;
    logic [1:0]        samp_early;
    logic [5:0]        mid;
    logic [5:0]        edge_pos;

    assign mid      = scale >> 1;
    assign edge_pos = {1'b0, edge_count};

    // The falling-edge cycle in IDLE already counts as sample 0 of the start bit.
    assign edge_cnt_en = !rst && ((state != IDLE) || !rx_in);

    // NOTE: every register below uses <= so all updates see the pre-edge values of their peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            par_fail   <= 1'b0;
            samp_bit   <= 1'b1;
            samp_early <= 2'b11;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            // Third sample is taken straight from the line so the vote is ready before edge_done.
            if (state != IDLE) begin
                if (edge_pos == mid - 6'd1) samp_early[0] <= rx_in;
                if (edge_pos == mid)        samp_early[1] <= rx_in;
                if (edge_pos == mid + 6'd1)
                    samp_bit <= (samp_early[0] & samp_early[1]) |
                                (samp_early[0] & rx_in) |
                                (samp_early[1] & rx_in);
            end

            case (state)
                IDLE: begin
                    if (!rx_in) state <= START;
                end
                START: begin
                    if (edge_done) begin
                        if (!samp_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (edge_done) begin
                        shift_reg <= {samp_bit, shift_reg[DATA_W-1:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) state <= par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (edge_done) begin
                        par_fail <= samp_bit != (^shift_reg ^ par_typ);
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (edge_done) begin
                        stp_err  <= !samp_bit;
                        par_err  <= par_fail & par_en;
                        if (samp_bit && !(par_fail && par_en)) begin
                            data_valid <= 1'b1;
                            p_data     <= shift_reg;
                        end
                        par_fail <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: models the edge counter, drives frames and scores the
// output pulses against a queue of expected results.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] scale = 6'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [4:0] edge_count;
    logic       edge_done;
    logic       edge_cnt_en;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    typedef struct {
        logic [7:0] pdata;
        logic       dv;
        logic       pe;
        logic       se;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       got;
    int         n_checks = 0;
    int         n_errs = 0;
    int         cyc = 0;
    logic [7:0] exp_pdata = 8'h00;

    uart_rx_fsm #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .scale       (scale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .edge_count  (edge_count),
        .edge_done   (edge_done),
        .edge_cnt_en (edge_cnt_en),
        .p_data      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream oversampling edge counter
    always @(posedge clk) begin
        if (rst || !edge_cnt_en)                    edge_count <= 5'd0;
        else if ({1'b0, edge_count} == scale - 6'd1) edge_count <= 5'd0;
        else                                          edge_count <= edge_count + 5'd1;
    end
    assign edge_done = ({1'b0, edge_count} == scale - 6'd1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) step();
    endtask

    // Drives one frame starting in the current cycle; glitch_idx flips sample scale/2 of that bit,
    // limit truncates the frame after that many bits (no result expected then).
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input int glitch_idx, input int limit);
        logic [10:0] bits;
        int          n;
        logic        pf;
        exp_t        e;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        n = 9;
        if (par_en) begin
            bits[n] = pbit;
            n = n + 1;
        end
        bits[n] = stop;
        n = n + 1;
        if (limit >= n) begin
            pf = par_en && (pbit != (^d ^ par_typ));
            e.dv = stop && !pf;
            e.pe = pf;
            e.se = !stop;
            if (e.dv) exp_pdata = d;
            e.pdata = exp_pdata;
            e.cyc = cyc + n * int'(scale);
            sb.push_back(e);
        end
        for (int i = 0; i < n && i < limit; i++) begin
            for (int k = 0; k < int'(scale); k++) begin
                rx_in = (i == glitch_idx && k == int'(scale) / 2) ? ~bits[i] : bits[i];
                step();
            end
        end
        rx_in = 1'b1;
    endtask

    // Scoreboard: every pulse cycle consumes one expected frame result
    always @(negedge clk) begin
        if (data_valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                check("data_valid", data_valid, got.dv);
                check("par_err", par_err, got.pe);
                check("stp_err", stp_err, got.se);
                check("p_data", p_data, got.pdata);
                check("pulse_cycle", cyc, got.cyc);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with the line low to prove edge_cnt_en is forced off
        rst = 1'b1;
        rx_in = 1'b0;
        repeat (3) step();
        check("rst_edge_cnt_en", edge_cnt_en, 1'b0);
        check("rst_p_data", p_data, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_par_err", par_err, 1'b0);
        check("rst_stp_err", stp_err, 1'b0);
        rx_in = 1'b1;
        step();
        rst = 1'b0;
        idle(3);
        check("idle_edge_cnt_en", edge_cnt_en, 1'b0);

        // scale 8, no parity, 0xA3
        scale = 6'd8;
        par_en = 1'b0;
        send_frame(8'hA3, 1'b0, 1'b1, -1, 99);
        idle(3);
        check("drain_a3", sb.size(), 0);

        // scale 16, even parity, good then bad parity bit
        scale = 6'd16;
        par_en = 1'b1;
        par_typ = 1'b0;
        send_frame(8'h55, 1'b0, 1'b1, -1, 99);
        idle(3);
        send_frame(8'h55, 1'b1, 1'b1, -1, 99);
        idle(3);
        check("drain_par", sb.size(), 0);

        // odd parity, good frame
        par_typ = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, -1, 99);
        idle(3);
        par_typ = 1'b0;
        par_en = 1'b0;

        // Start-bit glitch: low 3 cycles then high
        scale = 6'd8;
        rx_in = 1'b0;
        repeat (3) step();
        rx_in = 1'b1;
        check("glitch_en_start", edge_cnt_en, 1'b1);
        repeat (4) step();
        check("glitch_en_done", edge_cnt_en, 1'b1);
        check("glitch_edge_done", edge_done, 1'b1);
        step();
        check("glitch_en_idle", edge_cnt_en, 1'b0);
        idle(4);
        check("glitch_en_after", edge_cnt_en, 1'b0);

        // Stop bit held low
        send_frame(8'h0F, 1'b0, 1'b0, -1, 99);
        idle(3);
        check("drain_stop", sb.size(), 0);

        // Single-sample glitch at scale/2 inside data bit 3
        send_frame(8'h96, 1'b0, 1'b1, 4, 99);
        idle(3);
        check("drain_glitch", sb.size(), 0);

        // scale 32: two back-to-back frames, then reset in the middle of a third
        scale = 6'd32;
        send_frame(8'h00, 1'b0, 1'b1, -1, 99);
        send_frame(8'hFF, 1'b0, 1'b1, -1, 99);
        send_frame(8'h5A, 1'b0, 1'b1, -1, 5);
        rx_in = 1'b1;
        repeat (10) step();
        check("mid_frame_en", edge_cnt_en, 1'b1);
        rst = 1'b1;
        rx_in = 1'b0;
        step();
        check("midrst_edge_cnt_en", edge_cnt_en, 1'b0);
        check("midrst_p_data", p_data, 8'h00);
        exp_pdata = 8'h00;
        rx_in = 1'b1;
        step();
        rst = 1'b0;
        idle(40);
        check("post_rst_p_data", p_data, 8'h00);
        check("post_rst_en", edge_cnt_en, 1'b0);

        idle(5);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
